// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter granting one output module at a time the shared-cache read port,
// with a per-grant watchdog that forces release of a holder that never signals done.
module rd_port_arbiter #(
    parameter int unsigned PORT_NUB = 16,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned WIDTH_SEL = $clog2(PORT_NUB),
    localparam int unsigned WIDTH_WD  = $clog2(TIMEOUT + 1)
) (
    input  logic                 internal_clk,
    input  logic                 rst_n,
    input  logic [PORT_NUB-1:0]  req_in,
    input  logic [PORT_NUB-1:0]  done_in,
    output logic [PORT_NUB-1:0]  grant_out,
    output logic [WIDTH_SEL-1:0] grant_id,
    output logic                 grant_vld,
    output logic                 timeout_err,
    output logic [WIDTH_SEL-1:0] timeout_port
);

    localparam logic [WIDTH_WD-1:0]  WD_LAST  = WIDTH_WD'(TIMEOUT - 1);
    localparam logic [WIDTH_SEL-1:0] PTR_INIT = WIDTH_SEL'(PORT_NUB - 1);
    localparam logic [PORT_NUB-1:0]  ONE_HOT0 = {{(PORT_NUB - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRelease
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [WIDTH_SEL-1:0] ptr;
    logic [WIDTH_WD-1:0]  wd_cnt;

    logic                 win_found;
    logic [WIDTH_SEL-1:0] win_idx;
    logic [WIDTH_SEL-1:0] cand;
    logic                 hold_done;
    logic                 wd_expired;

    assign hold_done  = done_in[grant_id];
    assign wd_expired = (wd_cnt == WD_LAST);

    // Search starts just above the last holder and covers every index, so a sole
    // requester equal to ptr is still found on the final step.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(PORT_NUB); i++) begin
            cand = WIDTH_SEL'((int'(ptr) + 1 + i) % int'(PORT_NUB));
            if (!win_found && req_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (win_found) state_d = StHold;
            StHold:    if (hold_done || wd_expired) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_out    <= '0;
            grant_id     <= '0;
            grant_vld    <= 1'b0;
            ptr          <= PTR_INIT;
            wd_cnt       <= '0;
            timeout_err  <= 1'b0;
            timeout_port <= '0;
        end else begin
            state_q     <= state_d;
            timeout_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_out <= ONE_HOT0 << win_idx;
                        grant_id  <= win_idx;
                        grant_vld <= 1'b1;
                        wd_cnt    <= '0;
                    end
                end
                StHold: begin
                    if (hold_done || wd_expired) begin
                        grant_out <= '0;
                        grant_vld <= 1'b0;
                        ptr       <= grant_id;
                        // A done arriving on the expiry cycle wins: no error is flagged.
                        if (!hold_done) begin
                            timeout_err  <= 1'b1;
                            timeout_port <= grant_id;
                        end
                    end else if (!wd_expired) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Randomized bench for rd_port_arbiter: a holder/bubble/round-robin reference model is
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_rd_port_arbiter;

    localparam int N  = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req_in = '0;
    logic [N-1:0]  done_in = '0;
    logic [N-1:0]  grant_out;
    logic [3:0]    grant_id;
    logic          grant_vld;
    logic          timeout_err;
    logic [3:0]    timeout_port;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    rd_port_arbiter #(
        .PORT_NUB (N),
        .TIMEOUT  (TO)
    ) dut (
        .internal_clk (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .done_in      (done_in),
        .grant_out    (grant_out),
        .grant_id     (grant_id),
        .grant_vld    (grant_vld),
        .timeout_err  (timeout_err),
        .timeout_port (timeout_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the port, whether we are in the post-release bubble,
    // how many cycles the holder has kept it, and the last holder for round-robin.
    int m_holder = -1;
    int m_bubble = 0;
    int m_age    = 0;
    int m_last   = N - 1;
    int m_id     = 0;
    int m_terr   = 0;
    int m_tport  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder = -1; m_bubble = 0; m_age = 0; m_last = N - 1;
            m_id = 0; m_terr = 0; m_tport = 0;
        end else begin
            m_terr = 0;
            if (m_holder >= 0) begin
                if (done_in[m_holder] || m_age == TO - 1) begin
                    if (!done_in[m_holder]) begin
                        m_terr  = 1;
                        m_tport = m_holder;
                    end
                    m_last   = m_holder;
                    m_holder = -1;
                    m_bubble = 1;
                end else begin
                    m_age++;
                end
            end else if (m_bubble != 0) begin
                m_bubble = 0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (m_holder < 0 && req_in[(m_last + k) % N]) begin
                        m_holder = (m_last + k) % N;
                        m_id     = m_holder;
                        m_age    = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_go;
        exp_go = '0;
        if (m_holder >= 0) exp_go[m_holder] = 1'b1;
        chk("grant_out", 64'(grant_out), 64'(exp_go));
        chk("grant_vld", 64'(grant_vld), 64'(m_holder >= 0));
        chk("grant_id", 64'(grant_id), 64'(m_id));
        chk("timeout_err", 64'(timeout_err), 64'(m_terr));
        chk("timeout_port", 64'(timeout_port), 64'(m_tport));
        chk("onehot", 64'($countones(grant_out) <= 1), 64'd1);
        chk("vld_eq_or", 64'(grant_vld), 64'(|grant_out));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int port, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (grant_vld) break;
        end
        chk("grant_wait_vld", 64'(grant_vld), 64'd1);
        chk("grant_wait_id", 64'(grant_id), 64'(port));
    endtask

    initial begin
        int prev_cyc;
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_grant_out", 64'(grant_out), 64'd0);
        chk("rst_grant_vld", 64'(grant_vld), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_timeout_port", 64'(timeout_port), 64'd0);

        // Single requester: 1-cycle grant, 2-cycle gap after done, regrant to itself.
        rst_n  = 1'b1;
        req_in = 16'h0001;
        step();
        chk("p0_grant_out", 64'(grant_out), 64'h0001);
        chk("p0_grant_id", 64'(grant_id), 64'd0);
        done_in = 16'h0001;
        step();
        done_in = '0;
        chk("p0_gap1", 64'(grant_vld), 64'd0);
        chk("p0_gap1_id", 64'(grant_id), 64'd0);
        step();
        chk("p0_gap2", 64'(grant_vld), 64'd0);
        step();
        chk("p0_regrant", 64'(grant_out), 64'h0001);
        req_in  = '0;
        done_in = 16'h0001;
        step();
        done_in = '0;

        // All requesting, done 3 cycles after each grant: strict order, 6-cycle period.
        do_reset();
        req_in   = 16'hFFFF;
        prev_cyc = 0;
        for (int k = 0; k <= N; k++) begin
            wait_grant(k % N, 8);
            if (k > 0) chk("rr_period", 64'(cyc - prev_cyc), 64'd6);
            prev_cyc = cyc;
            repeat (3) step();
            done_in = 16'(1) << (k % N);
            step();
            done_in = '0;
        end
        req_in = '0;
        repeat (3) step();

        // Holder 5 never finishes: forced release after TO cycles, next goes to 7.
        do_reset();
        req_in = 16'h0020;
        wait_grant(5, 4);
        req_in = 16'h0088;
        for (int j = 1; j < TO; j++) begin
            step();
            chk("to_hold_vld", 64'(grant_vld), 64'd1);
            chk("to_no_err_yet", 64'(timeout_err), 64'd0);
        end
        step();
        chk("to_err_pulse", 64'(timeout_err), 64'd1);
        chk("to_port", 64'(timeout_port), 64'd5);
        chk("to_released", 64'(grant_vld), 64'd0);
        step();
        chk("to_err_clear", 64'(timeout_err), 64'd0);
        chk("to_port_hold", 64'(timeout_port), 64'd5);
        wait_grant(7, 2);
        req_in  = 16'h0008;
        done_in = 16'h0080;
        step();
        done_in = '0;
        wait_grant(3, 4);

        // Holder 3 finishes on the very cycle the watchdog expires: normal release.
        req_in = '0;
        repeat (TO - 1) step();
        done_in = 16'h0008;
        step();
        done_in = '0;
        chk("tie_no_err", 64'(timeout_err), 64'd0);
        chk("tie_released", 64'(grant_vld), 64'd0);
        chk("tie_port_kept", 64'(timeout_port), 64'd5);

        // A non-holder's done is ignored.
        req_in = 16'h0004;
        wait_grant(2, 4);
        req_in  = '0;
        done_in = 16'h0080;
        step();
        done_in = '0;
        chk("foreign_done_out", 64'(grant_out), 64'h0004);
        step();
        chk("foreign_done_id", 64'(grant_id), 64'd2);
        done_in = 16'h0004;
        step();
        done_in = '0;
        step();

        // Reset mid-hold drops the grant at once; ptr returns to N-1.
        req_in = 16'h0200;
        wait_grant(9, 4);
        req_in = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_drop_out", 64'(grant_out), 64'd0);
        chk("async_drop_vld", 64'(grant_vld), 64'd0);
        req_in = 16'h0600;
        step();
        rst_n = 1'b1;
        wait_grant(9, 1);
        req_in  = 16'h0400;
        done_in = 16'h0200;
        step();
        done_in = '0;
        wait_grant(10, 4);
        req_in  = '0;
        done_in = 16'h0400;
        step();
        done_in = '0;

        // Randomized traffic with occasional asynchronous resets.
        for (int it = 0; it < 3000; it++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (m_holder == i) req_in[i] = 1'b0;
                else if (!req_in[i] && $urandom_range(0, 11) == 0) req_in[i] = 1'b1;
            end
            done_in = '0;
            if (m_holder >= 0 && $urandom_range(0, 5) == 0) done_in[m_holder] = 1'b1;
            if ($urandom_range(0, 3) == 0) done_in[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #1 chk("rand_async_drop", 64'(grant_out), 64'd0);
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end

        req_in  = '0;
        done_in = '0;
        repeat (TO + 4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rd_port_arbiter.md
RD_PORT_ARBITER -- requirements
Module: rd_port_arbiter

Interface
REQ-001 Parameter PORT_NUB, default 16, number of output modules sharing the shared-cache read port; legal range 2..64.
REQ-002 Parameter TIMEOUT, default 1024, maximum HOLD cycles before forced release; legal range 4..65535.
REQ-003 Derived localparams (not overridable): WIDTH_SEL = $clog2(PORT_NUB); WIDTH_WD = $clog2(TIMEOUT+1).
REQ-004 internal_clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_in  input  PORT_NUB  level request per output module; held high until its grant arrives.
REQ-007 done_in  input  PORT_NUB  single-cycle release pulse from the current holder (its rd_done).
REQ-008 grant_out  output  PORT_NUB  registered one-hot read-port grant.
REQ-009 grant_id  output  WIDTH_SEL  binary index of current or last holder; drives the shared read-mux select.
REQ-010 grant_vld  output  1  high while any grant_out bit is high.
REQ-011 timeout_err  output  1  one-cycle pulse on forced release.
REQ-012 timeout_port  output  WIDTH_SEL  index of the last timed-out holder; holds until the next timeout.

Function
REQ-013 FSM states: IDLE, HOLD, RELEASE; registered state with a separate combinational next-state block.
REQ-014 IDLE: when any req_in bit is sampled high, the winner is chosen combinationally; on the same edge grant_out is set one-hot, grant_id is set, grant_vld rises, and the FSM goes to HOLD. Grant latency is 1 cycle from the req sample.
REQ-015 Selection is round-robin: search indices ptr+1, ptr+2, ... modulo PORT_NUB and take the first high req_in bit.
REQ-016 ptr is the last-granted index; it updates to grant_id on entry to RELEASE.
REQ-017 Wrap-around: when ptr = PORT_NUB-1, the search starts at index 0.
REQ-018 A sole requester equal to ptr is granted again, because the search covers all PORT_NUB indices.
REQ-019 HOLD: the grant is stable; the watchdog counter wd_cnt increments by 1 per cycle and is cleared to 0 on the grant edge.
REQ-020 HOLD release condition: done_in[grant_id] is high → go to RELEASE.
REQ-021 HOLD ignores done_in from non-holders and ignores the holder's req_in level.
REQ-022 HOLD forced release: wd_cnt == TIMEOUT-1 with no holder done → go to RELEASE.
REQ-023 On forced release, timeout_err pulses high for exactly the cycle following that edge, and timeout_port loads grant_id.
REQ-024 Simultaneous holder done and watchdog expiry: treated as a normal release; no timeout_err, timeout_port unchanged.
REQ-025 RELEASE lasts exactly 1 cycle: grant_out = 0, grant_vld = 0, grant_id holds the old value (mux bubble); then go to IDLE unconditionally.
REQ-026 Minimum spacing from a holder's done edge to the next grant edge is 2 cycles (RELEASE, then IDLE arbitration).
REQ-027 IDLE and RELEASE ignore done_in entirely.
REQ-028 At most one grant_out bit is high in any cycle; grant_vld == |grant_out at all times.
REQ-029 wd_cnt is WIDTH_WD wide, saturates at TIMEOUT-1, and is never compared outside HOLD.

Reset
REQ-030 Asynchronous assertion of rst_n forces: state = IDLE, grant_out = 0, grant_vld = 0, grant_id = 0, ptr = PORT_NUB-1, wd_cnt = 0, timeout_err = 0, timeout_port = 0.
REQ-031 Reset mid-HOLD drops the grant immediately, without waiting for an edge.
REQ-032 After rst_n deassertion, the first arbitration favours index 0.
REQ-033 No output glitches toward a grant during reset; the first grant can occur at the first edge after deassertion.

Verification
REQ-034 Reset, then req_in = 16'h0001 → grant_out = 16'h0001 and grant_id = 0 one edge later; done_in[0] pulse → grant_vld low for ≥2 cycles, then regrant to port 0.
REQ-035 req_in = 16'hFFFF held, each holder pulses done 3 cycles after grant → grants in order 0,1,...,15,0; exactly 6 cycles per grant period.
REQ-036 TIMEOUT = 8, holder 5 never asserts done → release after 8 HOLD cycles; timeout_err is a 1-cycle pulse; timeout_port = 5; next grant goes to the next requester above 5.
REQ-037 Holder 3 done coincides with wd_cnt == TIMEOUT-1 → normal release; timeout_err stays 0.
REQ-038 done_in[7] pulsed while port 2 holds → no effect, port 2 remains granted.
REQ-039 rst_n asserted mid-HOLD on port 9 → grant_out = 0 asynchronously; after release, req_in = 16'h0600 → port 9 granted first (ptr reset to 15, search starts at 0).
REQ-040 Throughout all scenarios, assert one-hot-or-zero grant_out and grant_vld == |grant_out every cycle.
